// File: rtl/ctrl.sv
// Main decoder/sequencer of the multi-cycle RISC-V core; LOAD is stretched to two cycles.
// Optional CTRL_ILLEGAL_EN adds an 'illegal' output and stalls the core on unsupported encodings.
module ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       b,
    output logic [2:0] imm_type,
    output logic [1:0] inst_sel,
    output logic       reg_wr,
    output logic [3:0] alu_op,
    output logic [2:0] cmp_op,
    output logic [1:0] pc_sel,
    output logic       mem_sel,
    output logic [1:0] rd_sel,
    output logic       alu1_sel,
    output logic       alu2_sel,
    output logic [2:0] sel_type,
    output logic       we
`ifdef CTRL_ILLEGAL_EN
    ,
    output logic       illegal
`endif
);

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_U    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_S    = 3'b011;
    localparam logic [2:0] IMM_I    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] PC_ALU  = 2'b00;
    localparam logic [1:0] PC_P4   = 2'b01;
    localparam logic [1:0] PC_HOLD = 2'b10;

    localparam logic [1:0] RD_IMM = 2'b00;
    localparam logic [1:0] RD_P4  = 2'b01;
    localparam logic [1:0] RD_ALU = 2'b10;
    localparam logic [1:0] RD_MEM = 2'b11;

    localparam logic [1:0] INST_NEW  = 2'b00;
    localparam logic [1:0] INST_HOLD = 2'b01;

    localparam logic [2:0] SEL_WORD = 3'b010;

    typedef enum logic {
        PH_ADDR = 1'b0,
        PH_WB   = 1'b1
    } phase_e;

    phase_e phase_q, phase_d;

    // Load phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Next phase and full decode
    always_comb begin
        phase_d  = PH_ADDR;
        imm_type = IMM_NONE;
        inst_sel = INST_NEW;
        reg_wr   = 1'b0;
        alu_op   = ALU_ADD;
        cmp_op   = 3'b000;
        pc_sel   = PC_P4;
        mem_sel  = 1'b0;
        rd_sel   = RD_ALU;
        alu1_sel = 1'b0;
        alu2_sel = 1'b1;
        sel_type = SEL_WORD;
        we       = 1'b0;
`ifdef CTRL_ILLEGAL_EN
        illegal  = 1'b0;
`endif

        if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
            unique case (func3)
                3'b000: alu_op = (opcode == OPC_OP && func7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                3'b001: alu_op = ALU_SLL;
                3'b010: alu_op = ALU_SLT;
                3'b011: alu_op = ALU_SLTU;
                3'b100: alu_op = ALU_XOR;
                3'b101: alu_op = (func7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                3'b110: alu_op = ALU_OR;
                3'b111: alu_op = ALU_AND;
                default: alu_op = ALU_ADD;
            endcase
        end

        case (opcode)
            OPC_OP: begin
                reg_wr   = 1'b1;
                alu2_sel = 1'b0;
`ifdef CTRL_ILLEGAL_EN
                illegal  = (func7 != 7'b0000000) && (func7 != F7_ALT);
`endif
            end
            OPC_OP_IMM: begin
                imm_type = IMM_I;
                reg_wr   = 1'b1;
            end
            OPC_LOAD: begin
                imm_type = IMM_I;
                rd_sel   = RD_MEM;
                sel_type = func3;
                if (phase_q == PH_ADDR) begin
                    phase_d  = PH_WB;
                    pc_sel   = PC_HOLD;
                    mem_sel  = 1'b1;
                    inst_sel = INST_HOLD;
                end else begin
                    reg_wr   = 1'b1;
                end
            end
            OPC_STORE: begin
                imm_type = IMM_S;
                sel_type = func3;
                we       = 1'b1;
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                alu1_sel = 1'b1;
                cmp_op   = func3;
                pc_sel   = b ? PC_ALU : PC_P4;
            end
            OPC_JAL: begin
                imm_type = IMM_J;
                alu1_sel = 1'b1;
                reg_wr   = 1'b1;
                rd_sel   = RD_P4;
                pc_sel   = PC_ALU;
            end
            OPC_JALR: begin
                imm_type = IMM_I;
                reg_wr   = 1'b1;
                rd_sel   = RD_P4;
                pc_sel   = PC_ALU;
            end
            OPC_LUI: begin
                imm_type = IMM_U;
                reg_wr   = 1'b1;
                rd_sel   = RD_IMM;
            end
            OPC_AUIPC: begin
                imm_type = IMM_U;
                alu1_sel = 1'b1;
                reg_wr   = 1'b1;
            end
            default: begin
`ifdef CTRL_ILLEGAL_EN
                illegal  = 1'b1;
`endif
            end
        endcase

`ifdef CTRL_ILLEGAL_EN
        // Unsupported encodings stall the core without side effects
        if (illegal) begin
            reg_wr = 1'b0;
            we     = 1'b0;
            pc_sel = PC_HOLD;
        end
`endif

        if (rst) begin
            reg_wr = 1'b0;
            we     = 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl.sv
// Self-checking bench for ctrl: per-cycle comparison against a table-driven decode model,
// plus directed literal checks covering the LOAD sequence and reset behaviour.
module tb_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       b;
    logic [2:0] imm_type;
    logic [1:0] inst_sel;
    logic       reg_wr;
    logic [3:0] alu_op;
    logic [2:0] cmp_op;
    logic [1:0] pc_sel;
    logic       mem_sel;
    logic [1:0] rd_sel;
    logic       alu1_sel;
    logic       alu2_sel;
    logic [2:0] sel_type;
    logic       we;
`ifdef CTRL_ILLEGAL_EN
    logic       illegal;
`endif

    int total = 0;
    int bad   = 0;
    bit run   = 0;
    logic m_ph;

    typedef struct packed {
        logic [2:0] imm;
        logic [1:0] inst;
        logic       wr;
        logic [3:0] alu;
        logic [2:0] cmp;
        logic [1:0] pc;
        logic       mem;
        logic [1:0] rd;
        logic       a1;
        logic       a2;
        logic [2:0] sel;
        logic       we;
        logic       ill;
    } exp_t;

    localparam logic [3:0] ALU_BY_F3 [8] = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h2, 4'h6, 4'h3, 4'h4};

    ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .func3    (func3),
        .func7    (func7),
        .b        (b),
        .imm_type (imm_type),
        .inst_sel (inst_sel),
        .reg_wr   (reg_wr),
        .alu_op   (alu_op),
        .cmp_op   (cmp_op),
        .pc_sel   (pc_sel),
        .mem_sel  (mem_sel),
        .rd_sel   (rd_sel),
        .alu1_sel (alu1_sel),
        .alu2_sel (alu2_sel),
        .sel_type (sel_type),
        .we       (we)
`ifdef CTRL_ILLEGAL_EN
        ,
        .illegal  (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the load phase: second cycle of a run of LOAD opcodes
    always @(posedge clk or posedge rst) begin
        if (rst) m_ph <= 1'b0;
        else     m_ph <= (opcode == 5'b00000) && !m_ph;
    end

    function automatic exp_t model(input logic [4:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic bb, input logic ph, input logic rs);
        exp_t e;
        logic wr;
        logic arith;
        logic alt;
        e      = '0;
        e.pc   = 2'b01;
        e.rd   = 2'b10;
        e.a2   = 1'b1;
        e.sel  = 3'b010;
        wr     = 1'b0;
        arith  = (o == 5'b01100) || (o == 5'b00100);
        alt    = (f7 == 7'h20) && ((f3 == 3'd5) || (f3 == 3'd0 && o == 5'b01100));
        if (arith) e.alu = ALU_BY_F3[f3] + 4'(alt);
        case (o)
            5'b01100: begin wr = 1'b1; e.a2 = 1'b0; e.ill = (f7 != 7'h00) && (f7 != 7'h20); end
            5'b00100: begin wr = 1'b1; e.imm = 3'd4; end
            5'b00000: begin
                e.imm = 3'd4; e.rd = 2'b11; e.sel = f3;
                if (ph) wr = 1'b1;
                else begin e.pc = 2'b10; e.mem = 1'b1; e.inst = 2'b01; end
            end
            5'b01000: begin e.imm = 3'd3; e.sel = f3; e.we = 1'b1; end
            5'b11000: begin e.imm = 3'd2; e.a1 = 1'b1; e.cmp = f3; e.pc = bb ? 2'b00 : 2'b01; end
            5'b11011: begin wr = 1'b1; e.imm = 3'd5; e.a1 = 1'b1; e.rd = 2'b01; e.pc = 2'b00; end
            5'b11001: begin wr = 1'b1; e.imm = 3'd4; e.rd = 2'b01; e.pc = 2'b00; end
            5'b01101: begin wr = 1'b1; e.imm = 3'd1; e.rd = 2'b00; end
            5'b00101: begin wr = 1'b1; e.imm = 3'd1; e.a1 = 1'b1; end
            default:  e.ill = 1'b1;
        endcase
`ifdef CTRL_ILLEGAL_EN
        if (e.ill) begin wr = 1'b0; e.we = 1'b0; e.pc = 2'b10; end
`endif
        e.wr = wr && !rs;
        if (rs) e.we = 1'b0;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a = {imm_type, inst_sel, reg_wr, alu_op, cmp_op, pc_sel, mem_sel, rd_sel,
             alu1_sel, alu2_sel, sel_type, we, 1'b0};
`ifdef CTRL_ILLEGAL_EN
        a.ill = illegal;
`endif
        return a;
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (run) begin
            exp_t e;
            exp_t a;
            e = model(opcode, func3, func7, b, m_ph, rst);
            a = actual();
`ifndef CTRL_ILLEGAL_EN
            e.ill = 1'b0;
`endif
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL decode op=%b f3=%b f7=%b b=%b rst=%b: got %h expected %h",
                         opcode, func3, func7, b, rst, a, e);
            end
        end
    end

    task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] o, input logic [2:0] f3, input logic [6:0] f7, input logic bb);
        @(posedge clk);
        #1;
        opcode = o; func3 = f3; func7 = f7; b = bb;
        #2;
    endtask

    localparam logic [2:0] F3S [4] = '{3'd0, 3'd1, 3'd5, 3'd4};
    localparam logic [6:0] F7S [4] = '{7'h00, 7'h20, 7'h20, 7'h01};

    initial begin
        rst = 1'b1; opcode = 5'b00000; func3 = 3'b010; func7 = 7'h00; b = 1'b0;
        run = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        lit("rst_load_pc_sel", 8'(pc_sel), 8'h2);
        lit("rst_load_mem_sel", 8'(mem_sel), 8'h1);
        lit("rst_load_inst_sel", 8'(inst_sel), 8'h1);
        lit("rst_load_reg_wr", 8'(reg_wr), 8'h0);
        lit("rst_we", 8'(we), 8'h0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #2;
        lit("load_ph1_pc_sel", 8'(pc_sel), 8'h1);
        lit("load_ph1_reg_wr", 8'(reg_wr), 8'h1);
        lit("load_ph1_rd_sel", 8'(rd_sel), 8'h3);
        @(posedge clk); #2;
        lit("load_ph0_again", 8'(pc_sel), 8'h2);
        @(posedge clk); #1;
        lit("load_ph1_before_rst", 8'(pc_sel), 8'h1);
        rst = 1'b1; #1;
        lit("mid_load_rst_pc_sel", 8'(pc_sel), 8'h2);
        lit("mid_load_rst_reg_wr", 8'(reg_wr), 8'h0);
        @(posedge clk); #1; rst = 1'b0;

        drive(5'b01100, 3'd0, 7'h20, 1'b0); lit("op_sub", 8'(alu_op), 8'h1);
        lit("op_alu2_sel", 8'(alu2_sel), 8'h0);
        lit("op_reg_wr", 8'(reg_wr), 8'h1);
        drive(5'b01100, 3'd0, 7'h00, 1'b0); lit("op_add", 8'(alu_op), 8'h0);
        drive(5'b01100, 3'd2, 7'h00, 1'b0); lit("op_slt", 8'(alu_op), 8'h8);
        drive(5'b01100, 3'd4, 7'h00, 1'b0); lit("op_xor", 8'(alu_op), 8'h2);
        drive(5'b01100, 3'd1, 7'h00, 1'b0); lit("op_sll", 8'(alu_op), 8'h5);
        drive(5'b01100, 3'd5, 7'h00, 1'b0); lit("op_srl", 8'(alu_op), 8'h6);
        drive(5'b01100, 3'd5, 7'h20, 1'b0); lit("op_sra", 8'(alu_op), 8'h7);
        drive(5'b00100, 3'd0, 7'h20, 1'b0); lit("addi_no_sub", 8'(alu_op), 8'h0);
        lit("opimm_imm", 8'(imm_type), 8'h4);
        lit("opimm_rd", 8'(rd_sel), 8'h2);
        drive(5'b01000, 3'd2, 7'h00, 1'b0);
        lit("store_alu", 8'(alu_op), 8'h0);
        lit("store_imm", 8'(imm_type), 8'h3);
        lit("store_wr", 8'(reg_wr), 8'h0);
        lit("store_we", 8'(we), 8'h1);
        drive(5'b11001, 3'd0, 7'h00, 1'b0);
        lit("jalr_pc", 8'(pc_sel), 8'h0);
        lit("jalr_rd", 8'(rd_sel), 8'h1);
        drive(5'b01101, 3'd0, 7'h00, 1'b0);
        lit("lui_imm", 8'(imm_type), 8'h1);
        lit("lui_rd", 8'(rd_sel), 8'h0);
        drive(5'b11011, 3'd0, 7'h00, 1'b0);
        lit("jal_alu1", 8'(alu1_sel), 8'h1);
        lit("jal_rd", 8'(rd_sel), 8'h1);
        drive(5'b00000, 3'd4, 7'h00, 1'b0);
        lit("load_alu1", 8'(alu1_sel), 8'h0);
        lit("load_sel_type", 8'(sel_type), 8'h4);
        drive(5'b10101, 3'd0, 7'h00, 1'b0);
        lit("undef_alu2", 8'(alu2_sel), 8'h1);
        lit("undef_wr", 8'(reg_wr), 8'h0);
        lit("undef_we", 8'(we), 8'h0);
        drive(5'b11000, 3'd1, 7'h00, 1'b0);
        lit("br_not_taken", 8'(pc_sel), 8'h1);
        lit("br_cmp", 8'(cmp_op), 8'h1);
        lit("br_wr", 8'(reg_wr), 8'h0);
        drive(5'b11000, 3'd1, 7'h00, 1'b1);
        lit("br_taken", 8'(pc_sel), 8'h0);

        // Sweep every opcode with a few func3/func7/b combinations
        for (int o = 0; o < 32; o++) begin
            for (int k = 0; k < 4; k++) begin
                drive(5'(o), F3S[k], F7S[k], 1'(k));
            end
        end
        for (int f = 0; f < 8; f++) begin
            drive(5'b01100, 3'(f), 7'h20, 1'b0);
            drive(5'b00100, 3'(f), 7'h20, 1'b1);
            drive(5'b00000, 3'(f), 7'h00, 1'b0);
            drive(5'b00000, 3'(f), 7'h00, 1'b0);
        end

        repeat (2) @(posedge clk);
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
